// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS fetch-stage sequencer.
package fetch_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_ent_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {ir, pc} holding slot for a fetch response that lands while D is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_unload,
    input  fetch_ent_t i_ent,
    output fetch_ent_t o_ent,
    output logic       o_full
);

    logic       r_full;
    fetch_ent_t r_ent;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    // NOTE: the payload is deliberately left out of reset; r_full alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_ent <= i_ent;
        end
    end

    assign o_ent  = r_ent;
    assign o_full = r_full;

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: PC, imem handshake, delay-slot redirects, stalls, IF/ID register.
// Optional request timeout detection is enabled by defining FETCH_TIMEOUT_EN.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_ir,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        fetch_err
);

    if (TIMEOUT >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow to hold TIMEOUT");
    end

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_pend;
    logic [31:0]  r_pend_pc;
    logic         r_if_valid;
    logic [31:0]  r_if_ir;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_pc4;

    logic         w_redirect;
    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_seq_pc;
    logic [31:0]  w_nxt_pc;
    logic         w_load_buf;
    logic         w_unload_buf;
    logic         w_buf_full;
    fetch_ent_t   w_buf_in;
    fetch_ent_t   w_buf_ent;

    assign w_redirect    = redirect_valid && !stall;
    assign w_redirect_pc = word_align(redirect_pc);
    assign w_seq_pc      = r_pend ? r_pend_pc : r_pc + 32'd4;
    // A redirect coinciding with the delay-slot response skips the pending step.
    assign w_nxt_pc      = w_redirect ? w_redirect_pc : w_seq_pc;
    assign w_load_buf    = (r_state == S_REQ) && imem_ready && stall;
    assign w_unload_buf  = (r_state == S_HOLD) && !stall;
    assign w_buf_in      = '{ir: imem_rdata, pc: r_pc};

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load_buf),
        .i_unload (w_unload_buf),
        .i_ent    (w_buf_in),
        .o_ent    (w_buf_ent),
        .o_full   (w_buf_full)
    );

    // NOTE: every register below is written with <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_pc  <= '0;
            r_if_valid <= 1'b0;
            r_if_ir    <= NOP;
            r_if_pc    <= '0;
            r_if_pc4   <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        r_pc   <= w_nxt_pc;
                        r_pend <= 1'b0;
                        if (stall) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_ir    <= imem_rdata;
                            r_if_pc    <= r_pc;
                            r_if_pc4   <= r_pc + 32'd4;
                        end
                    end else begin
                        if (!stall) begin
                            r_if_valid <= 1'b0;
                        end
                        if (w_redirect) begin
                            r_pend    <= 1'b1;
                            r_pend_pc <= w_redirect_pc;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && w_buf_full) begin
                        r_if_valid <= 1'b1;
                        r_if_ir    <= w_buf_ent.ir;
                        r_if_pc    <= w_buf_ent.pc;
                        r_if_pc4   <= w_buf_ent.pc + 32'd4;
                        r_state    <= S_REQ;
                        if (w_redirect) begin
                            r_pc <= w_redirect_pc;
                        end
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_ir     = r_if_ir;
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc4;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fetch_err;

    // Counter saturates at TIMEOUT; the request itself is never abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (r_state == S_REQ) begin
                if (imem_ready) begin
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt != TIMEOUT_CNT) begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
            end
            if (r_wait_cnt == TIMEOUT_CNT) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: vector table, imem model with scoreboard, directed corner cases.
`timescale 1ns/1ps
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    bit withhold = 1'b0;
    int addr_viol = 0;

`ifdef FETCH_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } sb_ent_t;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    sb_ent_t     sb[$];
    logic [31:0] hist[$];
    logic [31:0] req_log[$];

    fetch_seq dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // imem model: ready after `lat` request cycles; each accepted response goes to the scoreboard.
    initial begin : imem_model
        int          wcnt;
        bit          consumed;
        logic [31:0] held;
        wcnt = 0;
        held = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            consumed = imem_ready && imem_req && !reset;
            if (consumed) begin
                sb.push_back('{instr_of(imem_addr), imem_addr});
                req_log.push_back(imem_addr);
            end
            #2;
            if (reset || !imem_req) begin
                imem_ready = 1'b0;
                wcnt = 0;
            end else begin
                if (consumed) wcnt = 0;
                if (wcnt > 0 && imem_addr !== held) addr_viol++;
                held = imem_addr;
                wcnt++;
                imem_ready = (wcnt >= lat) && !withhold;
                imem_rdata = instr_of(imem_addr);
            end
        end
    end

    // Any unstalled edge that leaves if_valid high has loaded a new instruction.
    initial begin : monitor
        bit      st;
        bit      rs;
        sb_ent_t e;
        forever begin
            @(posedge clk);
            st = stall;
            rs = reset;
            #1;
            if (!rs && !st && if_valid) begin
                hist.push_back(if_pc);
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_ir", if_ir, e.ir);
                    check("sb_pc", if_pc, e.pc);
                    check("sb_pc4", if_pc4, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic do_reset(input string tag, input int l, input bit wh);
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        lat = l;
        withhold = wh;
        repeat (3) @(negedge clk);
        check({tag, "_rst_valid"}, if_valid, 32'd0);
        check({tag, "_rst_ir"}, if_ir, 32'd0);
        check({tag, "_rst_pc"}, if_pc, 32'd0);
        check({tag, "_rst_pc4"}, if_pc4, 32'd0);
        check({tag, "_rst_err"}, fetch_err, 32'd0);
        check({tag, "_rst_req"}, imem_req, 32'd1);
        check({tag, "_rst_addr"}, imem_addr, 32'h3000);
        sb.delete();
        hist.delete();
        req_log.delete();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        vec_t        vt[15];
        bit          found;
        int          n0;
        int          n3010;
        logic [31:0] exp_hist[9];

        vt[0]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h3000};
        vt[1]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3000, 32'h3004};
        vt[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3004, 32'h3008};
        vt[3]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3008, 32'h300C};
        vt[4]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008, 32'h3010};
        vt[5]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008, 32'h3010};
        vt[6]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008, 32'h3010};
        vt[7]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3008, 32'h3010};
        vt[8]  = '{1'b0, 1'b1, 32'h3200, 1'b1, 1'b1, 32'h300C, 32'h3200};
        vt[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3200, 32'h3204};
        vt[10] = '{1'b0, 1'b1, 32'h3300, 1'b1, 1'b1, 32'h3204, 32'h3300};
        vt[11] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3300, 32'h3304};
        vt[12] = '{1'b1, 1'b1, 32'h3400, 1'b0, 1'b1, 32'h3300, 32'h3308};
        vt[13] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3304, 32'h3308};
        vt[14] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3308, 32'h330C};
        exp_hist = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3200,
                     32'h3204, 32'h3300, 32'h3304, 32'h3308};

        // Latency 1: streaming, stall with buffered response, redirects in S_HOLD / with ready / under stall.
        do_reset("t1", 1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            stall = vt[i].stall;
            redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i), imem_req, vt[i].exp_req);
            check($sformatf("vec%0d_valid", i), if_valid, vt[i].exp_valid);
            check($sformatf("vec%0d_pc", i), if_pc, vt[i].exp_pc);
            if (vt[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
            @(negedge clk);
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t1_hist%0d", i), (hist.size() > i) ? hist[i] : 32'hDEAD_BEEF, exp_hist[i]);
        end
        n3010 = 0;
        foreach (req_log[k]) if (req_log[k] == 32'h3010 || req_log[k] == 32'h3400) n3010++;
        check("t5_skipped_never_fetched", n3010, 32'd0);

        // Latency 3, mid-operation reset: valid pattern 0,0,1 with stable address while waiting.
        do_reset("t2", 3, 1'b0);
        repeat (4) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t2_valid%0d", k), if_valid, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2) check($sformatf("t2_pc%0d", k), if_pc, 32'h3000 + 32'd4 * (k / 3 + 1));
        end

        // Latency 2: redirect while the delay slot is still in flight.
        do_reset("t4", 2, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk);
            #1;
            if (if_valid && if_pc == 32'h3008) found = 1'b1;
        end
        check("t4_reach_3008", found, 32'd1);
        @(negedge clk);
        n0 = hist.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3103;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4_req_held", imem_req, 32'd1);
        check("t4_addr_held", imem_addr, 32'h300C);
        repeat (8) @(negedge clk);
        check("t4_slot", (hist.size() > n0) ? hist[n0] : 32'hDEAD_BEEF, 32'h300C);
        check("t4_target", (hist.size() > n0 + 1) ? hist[n0 + 1] : 32'hDEAD_BEEF, 32'h3100);

        // Response withheld for 20 cycles.
        do_reset("t6", 1, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("t6_err_early", fetch_err, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("t6_err_late", fetch_err, EXP_ERR);
        check("t6_req_kept", imem_req, 32'd1);
        check("t6_addr_kept", imem_addr, 32'h3000);
        check("t6_no_valid", if_valid, 32'd0);
        @(negedge clk);
        withhold = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk);
            #1;
            if (if_valid) found = 1'b1;
        end
        check("t6_delivered", found, 32'd1);
        check("t6_late_pc", if_pc, 32'h3000);
        check("t6_err_sticky", fetch_err, EXP_ERR);

        check("addr_stable", addr_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
